// File: rtl/morse_decoder.sv
// Morse receive decoder: times marks/spaces on a synchronised key line, builds a
// dot/dash group and decodes it into the 3-bit S..Z letter code.
module morse_decoder #(
  parameter int TICKS_PER_UNIT = 25_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_in,
  output logic [2:0] letter,
  output logic       valid,
  output logic       error,
  output logic       busy
);

  localparam int CW = $clog2(5 * TICKS_PER_UNIT + 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_T2  = CW'(2 * TICKS_PER_UNIT);
  localparam logic [CW-1:0] C_T3  = CW'(3 * TICKS_PER_UNIT);
  localparam logic [CW-1:0] C_T5  = CW'(5 * TICKS_PER_UNIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_LONG  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_key_s;
  logic [CW-1:0]   r_run;
  logic [3:0]      r_sym;
  logic [2:0]      r_sym_cnt;
  logic            r_ovf;
  logic [2:0]      r_letter;
  logic            r_valid;
  logic            r_error;
  logic            r_busy;

  logic            w_key_nxt;
  logic            w_rise;
  logic            w_fall;
  logic            w_dash;
  logic [CW-1:0]   w_run_nxt;
  logic [3:0]      w_dec;

  // Returns {recognised, letter}; an overflowed group is never recognised.
  function automatic logic [3:0] f_decode(input logic [2:0] cnt, input logic [3:0] sym,
                                          input logic ovf);
    logic [3:0] res;
    res = 4'b0000;
    if (ovf) begin
      res = 4'b0000;
    end else begin
      case ({cnt, sym})
        7'b011_0000: res = {1'b1, 3'b000};
        7'b001_0001: res = {1'b1, 3'b001};
        7'b011_0001: res = {1'b1, 3'b010};
        7'b100_0001: res = {1'b1, 3'b011};
        7'b011_0011: res = {1'b1, 3'b100};
        7'b100_1001: res = {1'b1, 3'b101};
        7'b100_1011: res = {1'b1, 3'b110};
        7'b100_1100: res = {1'b1, 3'b111};
        default:     res = 4'b0000;
      endcase
    end
    return res;
  endfunction

  // The FSM acts on the value key_s is about to take, so every registered
  // output lines up with the key_s cycle that caused it.
  assign w_key_nxt = r_sync1;
  assign w_rise    = w_key_nxt & ~r_key_s;
  assign w_fall    = ~w_key_nxt & r_key_s;
  assign w_dash    = (r_run >= C_T2);
  assign w_dec     = f_decode(r_sym_cnt, r_sym, r_ovf);

  // Run length of the current key_s level, saturating at five units.
  always_comb begin
    w_run_nxt = r_run;
    if (w_key_nxt != r_key_s) begin
      w_run_nxt = C_ONE;
    end else if (r_run >= C_T5) begin
      w_run_nxt = C_T5;
    end else begin
      w_run_nxt = r_run + C_ONE;
    end
  end

  // Synchroniser, run counter, symbol buffer and decode FSM.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1   <= 1'b0;
      r_key_s   <= 1'b0;
      r_run     <= '0;
      r_state   <= S_IDLE;
      r_sym     <= 4'b0000;
      r_sym_cnt <= 3'd0;
      r_ovf     <= 1'b0;
      r_letter  <= 3'b000;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sync1 <= key_in;
      r_key_s <= r_sync1;
      r_run   <= w_run_nxt;
      r_valid <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_MARK;
            r_busy  <= 1'b1;
          end
        end
        S_MARK: begin
          if (w_fall) begin
            r_sym   <= {r_sym[2:0], w_dash};
            r_state <= S_SPACE;
            if (r_sym_cnt == 3'd4) begin
              r_ovf <= 1'b1;
            end else begin
              r_sym_cnt <= r_sym_cnt + 3'd1;
            end
          end else if (w_run_nxt == C_T5) begin
            r_state   <= S_LONG;
            r_sym     <= 4'b0000;
            r_sym_cnt <= 3'd0;
            r_ovf     <= 1'b0;
          end
        end
        S_SPACE: begin
          // A rise always wins, even on the cycle the gap would hit three units.
          if (w_rise) begin
            r_state <= S_MARK;
          end else if (w_run_nxt == C_T3) begin
            if (w_dec[3]) begin
              r_valid  <= 1'b1;
              r_letter <= w_dec[2:0];
            end else begin
              r_error <= 1'b1;
            end
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_sym     <= 4'b0000;
            r_sym_cnt <= 3'd0;
            r_ovf     <= 1'b0;
          end
        end
        S_LONG: begin
          if (w_fall) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_sym     <= 4'b0000;
          r_sym_cnt <= 3'd0;
          r_ovf     <= 1'b0;
        end
      endcase
    end
  end

  assign letter = r_letter;
  assign valid  = r_valid;
  assign error  = r_error;
  assign busy   = r_busy;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with TICKS_PER_UNIT = 4; inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_morse_decoder;

  logic       clock;
  logic       reset_n;
  logic       key_in;
  logic [2:0] letter;
  logic       valid;
  logic       error;
  logic       busy;

  int n_vec;
  int n_fail;

  morse_decoder #(.TICKS_PER_UNIT(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .key_in  (key_in),
    .letter  (letter),
    .valid   (valid),
    .error   (error),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_mark(input int len);
    key_in = 1'b1;
    repeat (len) tick();
    key_in = 1'b0;
  endtask

  // Sends n marks separated by gap-cycle spaces; ends on the final fall.
  task automatic send_group(input int n, input int m0, input int m1, input int m2,
                            input int m3, input int m4, input int gap);
    int m[5];
    m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3; m[4] = m4;
    for (int k = 0; k < n; k++) begin
      if (k != 0) repeat (gap) tick();
      send_mark(m[k]);
    end
  endtask

  // After the last fall of key_in the result must appear on tick 13
  // (2 synchroniser cycles + 12th low key_s cycle, less the shared first edge).
  task automatic expect_group(input string tag, input bit exp_ok, input int exp_letter);
    int first;
    int nv;
    int ne;
    int busy14;
    first = 0; nv = 0; ne = 0; busy14 = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((valid || error) && first == 0) first = i;
      if (valid) nv++;
      if (error) ne++;
      if (i == 14) busy14 = int'(busy);
    end
    chk({tag, " pulse tick"}, first, 13);
    chk({tag, " valid count"}, nv, exp_ok ? 1 : 0);
    chk({tag, " error count"}, ne, exp_ok ? 0 : 1);
    chk({tag, " letter"}, int'(letter), exp_letter);
    chk({tag, " busy after"}, busy14, 0);
  endtask

  initial begin
    int first;
    int nv;
    int ne;
    n_vec = 0;
    n_fail = 0;
    reset_n = 1'b0;
    key_in = 1'b0;
    repeat (3) tick();
    chk("reset letter", int'(letter), 0);
    chk("reset valid", int'(valid), 0);
    chk("reset error", int'(error), 0);
    chk("reset busy", int'(busy), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    send_group(3, 4, 4, 4, 0, 0, 4);
    expect_group("S", 1'b1, 0);

    // 25-cycle mark: LONG after 20 high cycles, error two ticks after release.
    key_in = 1'b1;
    repeat (25) tick();
    chk("long busy", int'(busy), 1);
    key_in = 1'b0;
    first = 0; nv = 0; ne = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (error && first == 0) first = i;
      if (valid) nv++;
      if (error) ne++;
    end
    chk("long error tick", first, 2);
    chk("long error count", ne, 1);
    chk("long valid count", nv, 0);
    chk("long busy after", int'(busy), 0);

    send_group(3, 4, 4, 4, 0, 0, 4);
    expect_group("S after long", 1'b1, 0);

    send_group(4, 12, 12, 4, 4, 0, 4);
    expect_group("Z", 1'b1, 7);

    send_group(3, 4, 12, 12, 0, 0, 8);
    expect_group("W 2T gaps", 1'b1, 4);

    send_group(4, 8, 8, 7, 7, 0, 4);
    expect_group("Z 8/7 boundary", 1'b1, 7);

    send_group(3, 4, 4, 12, 0, 0, 11);
    expect_group("U 11-cycle gaps", 1'b1, 2);

    send_group(2, 4, 12, 0, 0, 0, 4);
    expect_group("A unknown", 1'b0, 2);

    send_group(5, 4, 4, 4, 4, 4, 4);
    expect_group("five dots", 1'b0, 2);

    // Reset in the middle of V's third mark drops the group silently.
    send_group(2, 4, 4, 0, 0, 0, 4);
    repeat (4) tick();
    key_in = 1'b1;
    repeat (2) tick();
    key_in = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midreset letter", int'(letter), 0);
    chk("midreset valid", int'(valid), 0);
    chk("midreset error", int'(error), 0);
    chk("midreset busy", int'(busy), 0);
    nv = 0; ne = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (valid) nv++;
      if (error) ne++;
    end
    chk("midreset quiet valid", nv, 0);
    chk("midreset quiet error", ne, 0);

    send_mark(12);
    expect_group("T", 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
